// File: rtl/teclado_pkg.sv
// ---------------------------------------------------------------------------
// teclado_pkg
// Shared definitions for the keypad number-capture logic: the two special
// key codes, the capture FSM state type and a helper that sorts a raw key
// code into digit / clear / enter.
// ---------------------------------------------------------------------------
package teclado_pkg;

    localparam logic [3:0] TECLA_BORRAR = 4'hE;
    localparam logic [3:0] TECLA_ENTER  = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        ENTRADA,
        SALIDA
    } estado_captura_t;

    typedef enum logic [1:0] {
        CLASE_DIGITO,
        CLASE_BORRAR,
        CLASE_ENTER
    } clase_tecla_t;

    // Anything that is not one of the two command keys is a digit (0x0-0xD).
    function automatic clase_tecla_t clasificar_tecla(input logic [3:0] tecla);
        clase_tecla_t clase;
        if (tecla == TECLA_BORRAR) begin
            clase = CLASE_BORRAR;
        end else if (tecla == TECLA_ENTER) begin
            clase = CLASE_ENTER;
        end else begin
            clase = CLASE_DIGITO;
        end
        return clase;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// ---------------------------------------------------------------------------
// detector_flanco
// Rising-edge detector for a level flag. The previous-value register resets
// to 1 so a flag that is already high when reset is released does not look
// like a fresh edge.
//
// Ports:
//   clk_i     - system clock
//   reset_i   - asynchronous active-high reset
//   nivel_i   - level input to watch
//   flanco_o  - high for the cycle in which nivel_i is 1 and was 0 before
// ---------------------------------------------------------------------------
module detector_flanco (
    input  logic clk_i,
    input  logic reset_i,
    input  logic nivel_i,
    output logic flanco_o
);

    logic previo_q;

    // Remember last cycle's level; a held flag therefore produces one edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            previo_q <= 1'b1;
        end else begin
            previo_q <= nivel_i;
        end
    end

    assign flanco_o = nivel_i & ~previo_q;

endmodule

// File: rtl/captura_numero_teclado.sv
// ---------------------------------------------------------------------------
// captura_numero_teclado
// Assembles up to NUM_DIGITOS hex digits from the keypad into one number.
// Key 0xE clears the entry, key 0xF hands the number to the next stage over
// a valid/ready handshake. The partial number and digit count are exposed
// continuously for a live display.
//
// Ports:
//   clk_i              - system clock
//   reset_i            - asynchronous active-high reset
//   dato_codificado_i  - 4-bit key code, stable while data_available_i is high
//   data_available_i   - level flag, one key per 0->1 transition
//   numero_o           - finished number, meaningful while valid_o = 1
//   valid_o            - finished number available
//   ready_i            - downstream takes numero_o when valid_o & ready_i
//   numero_parcial_o   - accumulator contents
//   cuenta_digitos_o   - digits currently accumulated
//   tecla_ignorada_o   - one-cycle pulse for each discarded key
// ---------------------------------------------------------------------------
module captura_numero_teclado
    import teclado_pkg::*;
#(
    parameter int NUM_DIGITOS = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [3:0]                         dato_codificado_i,
    input  logic                               data_available_i,
    output logic [4*NUM_DIGITOS-1:0]           numero_o,
    output logic                               valid_o,
    input  logic                               ready_i,
    output logic [4*NUM_DIGITOS-1:0]           numero_parcial_o,
    output logic [$clog2(NUM_DIGITOS+1)-1:0]   cuenta_digitos_o,
    output logic                               tecla_ignorada_o
);

    localparam int W  = 4 * NUM_DIGITOS;
    localparam int CW = $clog2(NUM_DIGITOS + 1);
    localparam logic [CW-1:0] MAX_CUENTA = CW'(NUM_DIGITOS);

    estado_captura_t estado_q, estado_d;
    logic [W-1:0]    acum_q, acum_d;
    logic [W-1:0]    numero_q, numero_d;
    logic [CW-1:0]   cuenta_q, cuenta_d;
    logic            ignorada_q, ignorada_d;
    logic            evento;
    clase_tecla_t    clase;

    detector_flanco u_detector_flanco (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .nivel_i  (data_available_i),
        .flanco_o (evento)
    );

    assign clase = clasificar_tecla(dato_codificado_i);

    // State and datapath registers. Reset wipes any pending result at once.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            estado_q   <= IDLE;
            acum_q     <= '0;
            numero_q   <= '0;
            cuenta_q   <= '0;
            ignorada_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            acum_q     <= acum_d;
            numero_q   <= numero_d;
            cuenta_q   <= cuenta_d;
            ignorada_q <= ignorada_d;
        end
    end

    // Next-state logic. The shift is written as a left shift plus OR so it
    // also works when only one digit fits (it then acts as a plain load).
    // Digits beyond capacity are dropped rather than shifting older ones out.
    // While a result is pending every key, clear included, is discarded so
    // the number offered downstream cannot change under the handshake.
    always_comb begin
        estado_d   = estado_q;
        acum_d     = acum_q;
        numero_d   = numero_q;
        cuenta_d   = cuenta_q;
        ignorada_d = 1'b0;
        case (estado_q)
            IDLE: begin
                if (evento) begin
                    if (clase == CLASE_DIGITO) begin
                        acum_d   = W'(dato_codificado_i);
                        cuenta_d = CW'(1);
                        estado_d = ENTRADA;
                    end else if (clase == CLASE_ENTER) begin
                        ignorada_d = 1'b1;
                    end
                end
            end
            ENTRADA: begin
                if (evento) begin
                    if (clase == CLASE_DIGITO) begin
                        if (cuenta_q < MAX_CUENTA) begin
                            acum_d   = (acum_q << 4) | W'(dato_codificado_i);
                            cuenta_d = cuenta_q + CW'(1);
                        end else begin
                            ignorada_d = 1'b1;
                        end
                    end else if (clase == CLASE_BORRAR) begin
                        acum_d   = '0;
                        cuenta_d = '0;
                        estado_d = IDLE;
                    end else begin
                        numero_d = acum_q;
                        estado_d = SALIDA;
                    end
                end
            end
            SALIDA: begin
                if (evento) begin
                    ignorada_d = 1'b1;
                end
                if (ready_i) begin
                    acum_d   = '0;
                    cuenta_d = '0;
                    estado_d = IDLE;
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    assign valid_o          = (estado_q == SALIDA);
    assign numero_o         = numero_q;
    assign numero_parcial_o = acum_q;
    assign cuenta_digitos_o = cuenta_q;
    assign tecla_ignorada_o = ignorada_q;

endmodule

// File: tb/tb_captura_numero_teclado.sv
// ---------------------------------------------------------------------------
// tb_captura_numero_teclado
// Cycle-by-cycle table of keypad inputs and expected outputs for
// captura_numero_teclado (NUM_DIGITOS = 4), plus hand-written sequences for
// reset with the flag held high and asynchronous reset during a pending
// result.
// ---------------------------------------------------------------------------
module tb_captura_numero_teclado;

    logic        clock;
    logic        reset;
    logic [3:0]  dato;
    logic        dataAvail;
    logic [15:0] numero;
    logic        valid;
    logic        ready;
    logic [15:0] parcial;
    logic [2:0]  cuenta;
    logic        ignorada;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        da;
        logic [3:0]  tecla;
        logic        rdy;
        logic        expValid;
        logic [15:0] expNumero;
        logic [15:0] expParcial;
        logic [2:0]  expCuenta;
        logic        expIgn;
    } vec_t;

    vec_t vecs[$];

    captura_numero_teclado #(.NUM_DIGITOS(4)) dut (
        .clk_i             (clock),
        .reset_i           (reset),
        .dato_codificado_i (dato),
        .data_available_i  (dataAvail),
        .numero_o          (numero),
        .valid_o           (valid),
        .ready_i           (ready),
        .numero_parcial_o  (parcial),
        .cuenta_digitos_o  (cuenta),
        .tecla_ignorada_o  (ignorada)
    );

    // Free-running 10-unit clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison with a FAIL line on mismatch.
    task automatic checkValue(input string name, input int idx,
                              input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s step=%0d got=%h expected=%h", name, idx, actual, expected);
        end
    endtask

    // Table entry builder: one entry is one clock cycle.
    task automatic pushVec(input logic da, input logic [3:0] tecla, input logic rdy,
                           input logic v, input logic [15:0] n, input logic [15:0] p,
                           input logic [2:0] c, input logic i);
        vec_t e;
        e.da = da; e.tecla = tecla; e.rdy = rdy; e.expValid = v;
        e.expNumero = n; e.expParcial = p; e.expCuenta = c; e.expIgn = i;
        vecs.push_back(e);
    endtask

    // Key press (flag high) followed by its release cycle.
    task automatic pushKey(input logic [3:0] tecla, input logic rdy,
                           input logic v, input logic [15:0] n, input logic [15:0] p,
                           input logic [2:0] c, input logic i);
        pushVec(1'b1, tecla, rdy, v, n, p, c, i);
        pushVec(1'b0, tecla, rdy, v, n, p, c, 1'b0);
    endtask

    // Drive one table entry away from the active edge.
    task automatic applyStimulus(input vec_t e);
        @(negedge clock);
        dataAvail = e.da;
        dato      = e.tecla;
        ready     = e.rdy;
    endtask

    // Compare outputs just after the active edge against the table entry.
    task automatic checkOutput(input vec_t e, input int idx);
        checkValue("valid", idx, {15'd0, valid}, {15'd0, e.expValid});
        if (e.expValid) begin
            checkValue("numero", idx, numero, e.expNumero);
        end
        checkValue("parcial", idx, parcial, e.expParcial);
        checkValue("cuenta", idx, {13'd0, cuenta}, {13'd0, e.expCuenta});
        checkValue("ignorada", idx, {15'd0, ignorada}, {15'd0, e.expIgn});
    endtask

    initial begin
        reset     = 1'b1;
        dato      = 4'h0;
        dataAvail = 1'b0;
        ready     = 1'b0;
        $display("[TB] start");

        #12;
        checkValue("rst_valid", -1, {15'd0, valid}, 16'd0);
        checkValue("rst_numero", -1, numero, 16'd0);
        checkValue("rst_parcial", -1, parcial, 16'd0);
        checkValue("rst_cuenta", -1, {13'd0, cuenta}, 16'd0);
        checkValue("rst_ign", -1, {15'd0, ignorada}, 16'd0);
        @(negedge clock);
        reset = 1'b0;

        // 1 2 3 4 F with ready high: valid for exactly one cycle.
        pushVec(1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);
        pushKey(4'h1, 1'b1, 1'b0, 16'h0, 16'h0001, 3'd1, 1'b0);
        pushKey(4'h2, 1'b1, 1'b0, 16'h0, 16'h0012, 3'd2, 1'b0);
        pushKey(4'h3, 1'b1, 1'b0, 16'h0, 16'h0123, 3'd3, 1'b0);
        pushKey(4'h4, 1'b1, 1'b0, 16'h0, 16'h1234, 3'd4, 1'b0);
        pushVec(1'b1, 4'hF, 1'b1, 1'b1, 16'h1234, 16'h1234, 3'd4, 1'b0);
        pushVec(1'b0, 4'hF, 1'b1, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);
        pushVec(1'b0, 4'hF, 1'b1, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);

        // A B C D then overflow digit 5, then F.
        pushKey(4'hA, 1'b0, 1'b0, 16'h0, 16'h000A, 3'd1, 1'b0);
        pushKey(4'hB, 1'b0, 1'b0, 16'h0, 16'h00AB, 3'd2, 1'b0);
        pushKey(4'hC, 1'b0, 1'b0, 16'h0, 16'h0ABC, 3'd3, 1'b0);
        pushKey(4'hD, 1'b0, 1'b0, 16'h0, 16'hABCD, 3'd4, 1'b0);
        pushKey(4'h5, 1'b0, 1'b0, 16'h0, 16'hABCD, 3'd4, 1'b1);
        pushKey(4'hF, 1'b0, 1'b1, 16'hABCD, 16'hABCD, 3'd4, 1'b0);
        pushVec(1'b0, 4'hF, 1'b1, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);

        // 7 8 E 9 F, then F with nothing entered.
        pushKey(4'h7, 1'b0, 1'b0, 16'h0, 16'h0007, 3'd1, 1'b0);
        pushKey(4'h8, 1'b0, 1'b0, 16'h0, 16'h0078, 3'd2, 1'b0);
        pushKey(4'hE, 1'b0, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);
        pushKey(4'h9, 1'b0, 1'b0, 16'h0, 16'h0009, 3'd1, 1'b0);
        pushKey(4'hF, 1'b0, 1'b1, 16'h0009, 16'h0009, 3'd1, 1'b0);
        pushVec(1'b0, 4'hF, 1'b1, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);
        pushKey(4'hF, 1'b0, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b1);

        // 0x42 held against ready low, keys 3 and E discarded meanwhile.
        pushKey(4'h4, 1'b0, 1'b0, 16'h0, 16'h0004, 3'd1, 1'b0);
        pushKey(4'h2, 1'b0, 1'b0, 16'h0, 16'h0042, 3'd2, 1'b0);
        pushKey(4'hF, 1'b0, 1'b1, 16'h0042, 16'h0042, 3'd2, 1'b0);
        pushKey(4'h3, 1'b0, 1'b1, 16'h0042, 16'h0042, 3'd2, 1'b1);
        pushKey(4'hE, 1'b0, 1'b1, 16'h0042, 16'h0042, 3'd2, 1'b1);
        for (int k = 0; k < 4; k++) begin
            pushVec(1'b0, 4'hE, 1'b0, 1'b1, 16'h0042, 16'h0042, 3'd2, 1'b0);
        end
        pushVec(1'b0, 4'hE, 1'b1, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);

        // Key arriving on the transfer cycle is discarded.
        pushKey(4'h5, 1'b0, 1'b0, 16'h0, 16'h0005, 3'd1, 1'b0);
        pushKey(4'hF, 1'b0, 1'b1, 16'h0005, 16'h0005, 3'd1, 1'b0);
        pushVec(1'b1, 4'h6, 1'b1, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b1);
        pushVec(1'b0, 4'h6, 1'b0, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);

        // Flag held high for 20 cycles yields one digit.
        pushVec(1'b1, 4'h6, 1'b0, 1'b0, 16'h0, 16'h0006, 3'd1, 1'b0);
        for (int k = 0; k < 19; k++) begin
            pushVec(1'b1, 4'h6, 1'b0, 1'b0, 16'h0, 16'h0006, 3'd1, 1'b0);
        end
        pushVec(1'b0, 4'h6, 1'b0, 1'b0, 16'h0, 16'h0006, 3'd1, 1'b0);
        pushKey(4'hE, 1'b0, 1'b0, 16'h0, 16'h0000, 3'd0, 1'b0);

        foreach (vecs[idx]) begin
            applyStimulus(vecs[idx]);
            @(posedge clock);
            #1;
            checkOutput(vecs[idx], idx);
        end

        // Flag high across reset release: no key must be taken.
        @(negedge clock);
        dato      = 4'h3;
        dataAvail = 1'b1;
        reset     = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkValue("flagrst_parcial", -2, parcial, 16'd0);
        checkValue("flagrst_cuenta", -2, {13'd0, cuenta}, 16'd0);
        checkValue("flagrst_ign", -2, {15'd0, ignorada}, 16'd0);
        @(negedge clock);
        dataAvail = 1'b0;

        // Asynchronous reset while a result is pending.
        @(negedge clock);
        dato = 4'h7; dataAvail = 1'b1;
        @(negedge clock);
        dataAvail = 1'b0;
        @(negedge clock);
        dato = 4'hF; dataAvail = 1'b1; ready = 1'b0;
        @(posedge clock);
        #1;
        checkValue("pre_async_valid", -3, {15'd0, valid}, 16'd1);
        checkValue("pre_async_numero", -3, numero, 16'h0007);
        #1;
        reset = 1'b1;
        #1;
        checkValue("async_valid", -3, {15'd0, valid}, 16'd0);
        checkValue("async_numero", -3, numero, 16'd0);
        checkValue("async_parcial", -3, parcial, 16'd0);
        checkValue("async_cuenta", -3, {13'd0, cuenta}, 16'd0);
        dataAvail = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/captura_numero_teclado.md
Name: captura_numero_teclado

Overview:
- Downstream consumer of the hex keypad interface.
- Takes the encoded 4-bit key code and its level-type data-available flag, and assembles up to NUM_DIGITOS hex digits into a multi-digit number.
- Treats key 0xE as clear and key 0xF as enter.
- Presents the finished number to the next stage (display/arithmetic) through a valid/ready handshake, and exposes the partial number for live display.

Parameters:
- NUM_DIGITOS, 4, maximum digits accumulated; result width W = 4*NUM_DIGITOS; must be >= 1.

Ports:
- clk_i  input  1  system clock; the only clock; all state updates on its rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- dato_codificado_i  input  4  encoded key code from the keypad interface; stable while data_available_i is high.
- data_available_i  input  1  level flag; high while a captured key is held; one key per 0->1 transition.
- numero_o  output  W  completed number; valid only while valid_o = 1.
- valid_o  output  1  completed number available.
- ready_i  input  1  downstream accepts numero_o when valid_o & ready_i.
- numero_parcial_o  output  W  current accumulator contents, for 7-segment display.
- cuenta_digitos_o  output  $clog2(NUM_DIGITOS+1)  digits currently accumulated.
- tecla_ignorada_o  output  1  one-cycle pulse when a key event is discarded.

Behaviour:
- Reset (async, immediate): state IDLE; accumulator = 0; count = 0; numero_o = 0; valid_o = 0; tecla_ignorada_o = 0; edge register = 1.
  - Edge register resets to 1 so a flag already high at reset release is not taken as a key.
- Key event: evento = data_available_i & ~prev, where prev is data_available_i registered.
  - Acted on at the same clock edge; effects visible the following cycle.
  - A flag held high for many cycles yields exactly one event.
- Key classes:
  - 0x0-0xD = digit.
  - 0xE = clear.
  - 0xF = enter.
- States:
  - IDLE: count = 0.
    - Digit -> acc = digit, count = 1, go ENTRADA.
    - Clear -> no change.
    - Enter -> ignored, pulse tecla_ignorada_o.
  - ENTRADA: 1 <= count <= NUM_DIGITOS.
    - Digit with count < NUM_DIGITOS -> acc = {acc[W-5:0], digit}, count + 1.
    - Digit with count = NUM_DIGITOS -> acc unchanged, pulse tecla_ignorada_o (overflow; no wrap, no shift-out).
    - Clear -> acc = 0, count = 0, go IDLE.
    - Enter -> numero_o = acc, valid_o = 1, go SALIDA.
  - SALIDA: valid_o = 1; numero_o and numero_parcial_o held.
    - When valid_o & ready_i: valid_o = 0, acc = 0, count = 0, go IDLE next cycle.
    - Any key event while in SALIDA (including the transfer cycle) -> discarded, pulse tecla_ignorada_o.
    - This includes clear; a pending result cannot be cancelled.
- Handshake:
  - valid_o rises the cycle after the enter edge.
  - numero_o stays stable until transfer; valid_o never drops without ready_i.
  - ready_i is ignored outside SALIDA.
  - Minimum latency from enter event to possible transfer: 1 cycle.
- numero_parcial_o = acc at all times; cuenta_digitos_o = count.
- tecla_ignorada_o is exactly one cycle wide per discarded event.
- Reset mid-operation (including SALIDA with valid_o = 1): everything returns to reset values immediately; the pending result is lost.
- NUM_DIGITOS = 1: the shift degenerates to a load; boundary rules unchanged.

Decomposition:
- Package teclado_pkg:
  - TECLA_BORRAR = 4'hE.
  - TECLA_ENTER = 4'hF.
  - State enum estado_captura_t {IDLE, ENTRADA, SALIDA}.
  - Key-class helper function.
- One natural sub-module: detector_flanco.
  - Rising-edge detector with a reset-to-1 previous-value register.
  - Instantiated once.

Test Plan:
- Keys 1, 2, 3, 4, F; ready_i = 1 -> valid_o for exactly one cycle, numero_o = 16'h1234; then IDLE, numero_parcial_o = 0.
- Keys A, B, C, D, 5 (NUM_DIGITOS = 4) -> numero_parcial_o = 16'hABCD, cuenta_digitos_o = 4, tecla_ignorada_o pulse on 5; then F -> numero_o = 16'hABCD.
- Keys 7, 8, E, 9, F -> numero_o = 16'h0009; also F with count = 0 -> no valid_o, one tecla_ignorada_o pulse.
- Enter 0x42 with ready_i = 0 for 10 cycles, pressing 3 and E meanwhile -> valid_o and numero_o = 16'h0042 held, two ignored pulses; ready_i = 1 -> transfer, IDLE.
- data_available_i held high 20 cycles with key 6 -> exactly one digit accepted; data_available_i high during and after reset release -> no event.
- Assert reset_i mid-cycle while in SALIDA -> valid_o, numero_o, numero_parcial_o, and cuenta_digitos_o go to 0 immediately, without waiting for a clock edge.
